// File: rtl/switch_allocator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : switch_allocator_pkg
// Brief    : Shared router constants, flit type codes and output-port states.
// Revision : 1.0 - initial release
// ============================================================================
package switch_allocator_pkg;

    localparam int c_num_port   = 5;
    localparam int c_num_vc     = 4;
    localparam int c_route_len  = 3;
    localparam int c_credit_max = 4;
    localparam int c_credit_w   = 3;

    typedef enum logic [1:0] {
        FLIT_HEAD   = 2'b00,
        FLIT_BODY   = 2'b01,
        FLIT_TAIL   = 2'b10,
        FLIT_SINGLE = 2'b11
    } flit_type_t;

    typedef enum logic [0:0] {
        ST_FREE   = 1'b0,
        ST_LOCKED = 1'b1
    } port_state_t;

endpackage
`default_nettype wire

// File: rtl/switch_allocator_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : N-way arbiter, one-hot grant plus index. Rotating priority from
//            ptr when SA_ROUND_ROBIN_EN is defined, else lowest index wins.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N     = 20,
    parameter int IDX_W = 5
) (
`ifdef SA_ROUND_ROBIN_EN
    input  logic [IDX_W-1:0] ptr,
`endif
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

`ifdef SA_ROUND_ROBIN_EN
    // Scan begins at ptr and wraps; the first requester met wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!valid && req[(int'(ptr) + k) % N]) begin
                gnt[(int'(ptr) + k) % N] = 1'b1;
                idx   = IDX_W'((int'(ptr) + k) % N);
                valid = 1'b1;
            end
        end
    end
`else
    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!valid && req[i]) begin
                gnt[i] = 1'b1;
                idx    = IDX_W'(i);
                valid  = 1'b1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/switch_allocator.sv
`default_nettype none
// ============================================================================
// Module   : switch_allocator
// Brief    : Wormhole switch allocator with per-output locks and credits.
//            SA_ROUND_ROBIN_EN selects rotating-priority arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module switch_allocator #(
    parameter int NUM_PORT   = switch_allocator_pkg::c_num_port,
    parameter int NUM_VC     = switch_allocator_pkg::c_num_vc,
    parameter int ROUTE_LEN  = switch_allocator_pkg::c_route_len,
    parameter int CREDIT_MAX = switch_allocator_pkg::c_credit_max,
    parameter int SEL_W      = $clog2(NUM_PORT * NUM_VC)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_PORT*NUM_VC-1:0]            req,
    input  logic [NUM_PORT*NUM_VC-1:0]            head,
    input  logic [NUM_PORT*NUM_VC-1:0]            tail,
    input  logic [NUM_PORT*NUM_VC*ROUTE_LEN-1:0]  route,
    input  logic [NUM_PORT-1:0]                   credit_ret,
    output logic [NUM_PORT*NUM_VC-1:0]            grant,
    output logic [NUM_PORT-1:0]                   xbar_valid,
    output logic [NUM_PORT*SEL_W-1:0]             xbar_sel,
    output logic [NUM_PORT*3-1:0]                 credit
);
    import switch_allocator_pkg::*;

    localparam int c_n = NUM_PORT * NUM_VC;

    port_state_t            r_state  [NUM_PORT];
    logic [SEL_W-1:0]       r_owner  [NUM_PORT];
    logic [c_credit_w-1:0]  r_credit [NUM_PORT];

    port_state_t            w_state_nxt  [NUM_PORT];
    logic [SEL_W-1:0]       w_owner_nxt  [NUM_PORT];
    logic [c_credit_w-1:0]  w_credit_nxt [NUM_PORT];

    logic [c_n-1:0]         w_cand    [NUM_PORT];
    logic [c_n-1:0]         w_arb_gnt [NUM_PORT];
    logic [SEL_W-1:0]       w_arb_idx [NUM_PORT];
    logic                   w_arb_vld [NUM_PORT];
    logic [NUM_PORT-1:0]    w_win;
    logic [NUM_PORT-1:0]    w_lane_busy;

`ifdef SA_ROUND_ROBIN_EN
    logic [SEL_W-1:0]       r_ptr [NUM_PORT];
`endif

    // Candidate set: head flits routed here when FREE, only the owner when LOCKED.
    always_comb begin
        for (int p = 0; p < NUM_PORT; p++) begin
            w_cand[p] = '0;
            if (r_credit[p] != '0) begin
                if (r_state[p] == ST_LOCKED) begin
                    w_cand[p][r_owner[p]] = req[r_owner[p]];
                end else begin
                    for (int i = 0; i < c_n; i++) begin
                        w_cand[p][i] = req[i] & head[i] &
                            (route[i*ROUTE_LEN +: ROUTE_LEN] == ROUTE_LEN'(p));
                    end
                end
            end
        end
    end

    generate
        for (genvar gp = 0; gp < NUM_PORT; gp++) begin : g_arb
            rr_arbiter #(
                .N     (c_n),
                .IDX_W (SEL_W)
            ) u_arb (
`ifdef SA_ROUND_ROBIN_EN
                .ptr   (r_ptr[gp]),
`endif
                .req   (w_cand[gp]),
                .gnt   (w_arb_gnt[gp]),
                .idx   (w_arb_idx[gp]),
                .valid (w_arb_vld[gp])
            );
        end
    endgenerate

    // One crossbar lane per input port: the lowest-numbered output claims it.
    always_comb begin
        w_lane_busy = '0;
        w_win       = '0;
        grant       = '0;
        xbar_valid  = '0;
        xbar_sel    = '0;
        if (!rst) begin
            for (int p = 0; p < NUM_PORT; p++) begin
                if (w_arb_vld[p] && !w_lane_busy[w_arb_idx[p] / NUM_VC]) begin
                    w_lane_busy[w_arb_idx[p] / NUM_VC] = 1'b1;
                    w_win[p]                     = 1'b1;
                    grant                        = grant | w_arb_gnt[p];
                    xbar_valid[p]                = 1'b1;
                    xbar_sel[p*SEL_W +: SEL_W]   = w_arb_idx[p];
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PORT; p++) begin
            w_state_nxt[p]  = r_state[p];
            w_owner_nxt[p]  = r_owner[p];
            w_credit_nxt[p] = r_credit[p];
            if (w_win[p]) begin
                if (r_state[p] == ST_FREE && !tail[w_arb_idx[p]]) begin
                    w_state_nxt[p] = ST_LOCKED;
                    w_owner_nxt[p] = w_arb_idx[p];
                end else if (r_state[p] == ST_LOCKED && tail[w_arb_idx[p]]) begin
                    w_state_nxt[p] = ST_FREE;
                end
                if (!credit_ret[p]) begin
                    w_credit_nxt[p] = r_credit[p] - 1'b1;
                end
            end else if (credit_ret[p] && r_credit[p] < c_credit_w'(CREDIT_MAX)) begin
                w_credit_nxt[p] = r_credit[p] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORT; p++) begin
            if (rst) begin
                r_state[p]  <= ST_FREE;
                r_owner[p]  <= '0;
                r_credit[p] <= c_credit_w'(CREDIT_MAX);
            end else begin
                r_state[p]  <= w_state_nxt[p];
                r_owner[p]  <= w_owner_nxt[p];
                r_credit[p] <= w_credit_nxt[p];
            end
        end
    end

`ifdef SA_ROUND_ROBIN_EN
    // Only FREE-state wins rotate priority; packet continuation leaves it alone.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORT; p++) begin
            if (rst) begin
                r_ptr[p] <= '0;
            end else if (w_win[p] && r_state[p] == ST_FREE) begin
                r_ptr[p] <= (w_arb_idx[p] == SEL_W'(c_n - 1)) ? '0 : w_arb_idx[p] + 1'b1;
            end
        end
    end
`endif

    always_comb begin
        for (int p = 0; p < NUM_PORT; p++) begin
            credit[p*3 +: 3] = r_credit[p];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_switch_allocator.sv
`default_nettype none
// ============================================================================
// Module   : tb_switch_allocator
// Brief    : Directed bench for switch_allocator with an in-bench reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_switch_allocator;

    localparam int NP = 5;
    localparam int NV = 4;
    localparam int N  = NP * NV;
    localparam int RL = 3;
    localparam int SW = 5;
    localparam int CM = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req, head, tail;
    logic [N*RL-1:0]   route;
    logic [NP-1:0]     credit_ret;
    logic [N-1:0]      grant;
    logic [NP-1:0]     xbar_valid;
    logic [NP*SW-1:0]  xbar_sel;
    logic [NP*3-1:0]   credit;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: m_* is current, n_* is what the next edge will load.
    int m_cred [NP] = '{CM, CM, CM, CM, CM};
    int m_owner[NP] = '{0, 0, 0, 0, 0};
    int m_ptr  [NP] = '{0, 0, 0, 0, 0};
    bit m_lock [NP] = '{0, 0, 0, 0, 0};
    int n_cred [NP] = '{CM, CM, CM, CM, CM};
    int n_owner[NP] = '{0, 0, 0, 0, 0};
    int n_ptr  [NP] = '{0, 0, 0, 0, 0};
    bit n_lock [NP] = '{0, 0, 0, 0, 0};

    switch_allocator dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .head       (head),
        .tail       (tail),
        .route      (route),
        .credit_ret (credit_ret),
        .grant      (grant),
        .xbar_valid (xbar_valid),
        .xbar_sel   (xbar_sel),
        .credit     (credit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_vc(input int i, input bit r, input bit h, input bit t, input int rt);
        req[i]            = r;
        head[i]           = h;
        tail[i]           = t;
        route[i*RL +: RL] = RL'(rt);
    endtask

    task automatic clear_all();
        req = '0; head = '0; tail = '0; route = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Model: per output, pick the best eligible VC by priority key, then let
    // outputs claim input lanes in ascending order.
    always @(negedge clk) begin : b_model
        logic [N-1:0]     eg;
        logic [NP-1:0]    ev;
        logic [NP*SW-1:0] es;
        logic [NP*3-1:0]  ec;
        bit               lane_used [NP];
        int               win [NP];
        int               best, bkey, key;
        bit               ok;
        eg = '0; ev = '0; es = '0; ec = '0;
        for (int p = 0; p < NP; p++) begin
            lane_used[p] = 1'b0;
            win[p]       = -1;
            ec[p*3 +: 3] = 3'(m_cred[p]);
        end
        if (!rst) begin
            for (int p = 0; p < NP; p++) begin
                best = -1;
                bkey = N;
                if (m_cred[p] > 0) begin
                    for (int i = 0; i < N; i++) begin
                        if (m_lock[p]) ok = (i == m_owner[p]) && req[i];
                        else           ok = req[i] && head[i] && (int'(route[i*RL +: RL]) == p);
`ifdef SA_ROUND_ROBIN_EN
                        key = (i - m_ptr[p] + N) % N;
`else
                        key = i;
`endif
                        if (ok && key < bkey) begin
                            bkey = key;
                            best = i;
                        end
                    end
                end
                if (best >= 0 && !lane_used[best / NV]) begin
                    lane_used[best / NV] = 1'b1;
                    win[p]               = best;
                    eg[best]             = 1'b1;
                    ev[p]                = 1'b1;
                    es[p*SW +: SW]       = SW'(best);
                end
            end
        end
        chk("grant", grant, eg);
        chk("xbar_valid", xbar_valid, ev);
        chk("xbar_sel", xbar_sel, es);
        chk("credit", credit, ec);
        for (int p = 0; p < NP; p++) begin
            if (rst) begin
                n_cred[p] = CM; n_owner[p] = 0; n_ptr[p] = 0; n_lock[p] = 1'b0;
            end else begin
                n_cred[p]  = m_cred[p] + (credit_ret[p] ? 1 : 0) - (win[p] >= 0 ? 1 : 0);
                if (n_cred[p] > CM) n_cred[p] = CM;
                n_owner[p] = m_owner[p];
                n_lock[p]  = m_lock[p];
                n_ptr[p]   = m_ptr[p];
                if (win[p] >= 0) begin
                    if (!m_lock[p]) begin
                        n_ptr[p] = (win[p] + 1) % N;
                        if (!tail[win[p]]) begin
                            n_lock[p]  = 1'b1;
                            n_owner[p] = win[p];
                        end
                    end else if (tail[win[p]]) begin
                        n_lock[p] = 1'b0;
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        m_cred  = n_cred;
        m_owner = n_owner;
        m_ptr   = n_ptr;
        m_lock  = n_lock;
    end

    logic [N-1:0] t4_exp [3];

    initial begin
`ifdef SA_ROUND_ROBIN_EN
        t4_exp = '{20'h00010, 20'h00100, 20'h01000};
`else
        t4_exp = '{20'h00010, 20'h00010, 20'h00010};
`endif
        clear_all();
        credit_ret = '0;
        rst = 1'b1;

        // Reset: requests present but no grant during rst.
        tick(); set_vc(0, 1, 1, 1, 2);
        settle();
        chk("rst_grant", grant, 20'h0);
        chk("rst_valid", xbar_valid, 5'h0);
        chk("rst_credit", credit, 15'h4924);

        // Single flit VC0 -> out2, same-cycle grant.
        tick(); rst = 1'b0;
        settle();
        chk("t1_grant", grant, 20'h00001);
        chk("t1_valid", xbar_valid, 5'b00100);
        chk("t1_sel2", xbar_sel[14:10], 5'd0);
        tick(); set_vc(0, 0, 0, 0, 0); set_vc(6, 1, 1, 1, 2); credit_ret = 5'b00100;
        settle();
        chk("t1_credit2", credit[8:6], 3'd3);
        chk("t1_free_again", grant, 20'h00040);
        tick(); set_vc(6, 0, 0, 0, 0); credit_ret = '0;
        settle();
        chk("ret_and_grant", credit[8:6], 3'd3);
        tick(); credit_ret = 5'b00100;
        tick(); credit_ret = '0;
        settle();
        chk("ret_refill", credit[8:6], 3'd4);
        tick(); credit_ret = 5'b00100;
        tick(); credit_ret = '0;
        settle();
        chk("ret_saturate", credit[8:6], 3'd4);

        // Wormhole lock: VC1 H/B/T on out1 while VC5 waits with a HEAD.
        tick(); set_vc(1, 1, 1, 0, 1); set_vc(5, 1, 1, 0, 1); credit_ret = 5'b00010;
        settle(); chk("t2_head", grant, 20'h00002);
        tick(); set_vc(1, 1, 0, 0, 1);
        settle(); chk("t2_body", grant, 20'h00002);
        tick(); set_vc(1, 1, 0, 1, 1);
        settle(); chk("t2_tail", grant, 20'h00002);
        tick(); set_vc(1, 0, 0, 0, 0);
        settle(); chk("t2_vc5", grant, 20'h00020);
        chk("t2_sel1", xbar_sel[9:5], 5'd5);
        tick(); set_vc(5, 1, 0, 1, 1);
        settle(); chk("t2_vc5_tail", grant, 20'h00020);
        tick(); set_vc(5, 0, 0, 0, 0); credit_ret = '0;
        settle(); chk("t2_credit1", credit[5:3], 3'd4);

        // Credit exhaustion on out3.
        tick(); set_vc(8, 1, 1, 1, 3);
        for (int k = 0; k < 4; k++) begin
            settle(); chk("t3_grant", grant, 20'h00100);
            tick();
        end
        settle();
        chk("t3_credit0", credit[11:9], 3'd0);
        chk("t3_model_credit0", m_cred[3], 0);
        chk("t3_blocked", grant, 20'h0);
        credit_ret = 5'b01000;
        settle(); chk("t3_ret_not_yet", grant, 20'h0);
        tick(); credit_ret = '0;
        settle(); chk("t3_after_ret", grant, 20'h00100);
        tick(); set_vc(8, 0, 0, 0, 0);
        settle(); chk("t3_credit_back0", credit[11:9], 3'd0);
        credit_ret = 5'b01000;
        tick(); tick(); tick();
        set_vc(8, 1, 1, 1, 3);
        settle(); chk("t3_refill_grant", grant, 20'h00100);
        tick(); set_vc(8, 0, 0, 0, 0);
        settle(); chk("t3_ret_grant_same", credit[11:9], 3'd3);
        tick(); credit_ret = '0;
        settle(); chk("t3_full", credit[11:9], 3'd4);

        // Three input ports contend for out0.
        tick(); set_vc(4, 1, 1, 1, 0); set_vc(8, 1, 1, 1, 0); set_vc(12, 1, 1, 1, 0);
        credit_ret = 5'b00001;
        for (int k = 0; k < 3; k++) begin
            settle(); chk("t4_order", grant, t4_exp[k]);
            tick();
        end
        clear_all(); credit_ret = '0;

        // Input-lane conflict plus an out-of-range route.
        tick(); set_vc(0, 1, 1, 1, 1); set_vc(2, 1, 1, 1, 3); set_vc(9, 1, 1, 1, 6);
        settle();
        chk("t5_grant", grant, 20'h00001);
        chk("t5_valid", xbar_valid, 5'b00010);
        chk("t5_sel1", xbar_sel[9:5], 5'd0);
        tick(); clear_all();
        settle();
        chk("t5_credit3", credit[11:9], 3'd4);
        chk("t5_credit1", credit[5:3], 3'd3);

        // Reset in the middle of a packet drops the lock.
        tick(); set_vc(1, 1, 1, 0, 1);
        settle(); chk("t6_head", grant, 20'h00002);
        tick(); set_vc(1, 1, 0, 0, 1); rst = 1'b1;
        settle(); chk("t6_rst_grant", grant, 20'h0);
        tick(); rst = 1'b0; set_vc(5, 1, 1, 0, 1);
        settle();
        chk("t6_credit", credit, 15'h4924);
        chk("t6_unlocked", grant, 20'h00020);
        tick(); clear_all();
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
